// File: rtl/in_rd_controller_fsm.sv
// Input-side read controller: moves one held frame from the FWFT input FIFO into the shared cache.
// Defining IN_RD_GNT_TIMEOUT_EN adds a grant timeout that discards the frame instead.
module in_rd_controller_fsm #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_WIDTH      = 10,
   parameter int unsigned PORT_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_done,
   input  logic [DATA_WIDTH-1:0] ctrl_data,
   output logic                  frame_ready,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  cache_req,
   output logic [PORT_WIDTH-1:0] cache_dest,
   output logic [LEN_WIDTH-1:0]  cache_len,
   input  logic                  cache_gnt,
   output logic                  cache_wr_valid,
   input  logic                  cache_wr_ready,
   output logic [DATA_WIDTH-1:0] cache_wr_data,
   output logic                  cache_wr_sop,
   output logic                  cache_wr_eop,
   output logic                  busy,
   output logic                  drop
);

   localparam int unsigned CTRL_W = LEN_WIDTH + PORT_WIDTH;

`ifdef IN_RD_GNT_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, REQ, XFER, RELEASE, DROP} state_e;
`else
   typedef enum logic [2:0] {IDLE, LOAD, REQ, XFER, RELEASE} state_e;
`endif

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]  len_c, len_m1_c;
`ifdef IN_RD_GNT_TIMEOUT_EN
   logic [TMR_W-1:0]      tmr_q, tmr_d;
`endif

   assign len_c      = ctrl_q[LEN_WIDTH-1:0];
   assign len_m1_c   = len_c - LEN_WIDTH'(1);
   assign cache_len  = len_c;
   assign cache_dest = ctrl_q[CTRL_W-1:LEN_WIDTH];
   assign busy       = (state_q != IDLE);

   // Control-word bits above the len/dest fields carry nothing for this block.
   if (DATA_WIDTH > CTRL_W) begin : g_ctrl_hi
      logic unused_ctrl_hi;
      assign unused_ctrl_hi = ^ctrl_q[DATA_WIDTH-1:CTRL_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef IN_RD_GNT_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`endif

   always_comb begin
      state_d        = state_q;
      ctrl_d         = ctrl_q;
      cnt_d          = cnt_q;
`ifdef IN_RD_GNT_TIMEOUT_EN
      tmr_d          = tmr_q;
`endif
      frame_ready    = 1'b0;
      fifo_rd_en     = 1'b0;
      cache_req      = 1'b0;
      cache_wr_valid = 1'b0;
      cache_wr_data  = '0;
      cache_wr_sop   = 1'b0;
      cache_wr_eop   = 1'b0;
      drop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_done) state_d = LOAD;
         end
         LOAD: begin
            ctrl_d = ctrl_data;
            cnt_d  = '0;
`ifdef IN_RD_GNT_TIMEOUT_EN
            tmr_d  = '0;
`endif
            if (ctrl_data[LEN_WIDTH-1:0] == '0) state_d = RELEASE;
            else                                 state_d = REQ;
         end
         REQ: begin
            cache_req = 1'b1;
            if (cache_gnt) begin
               state_d = XFER;
`ifdef IN_RD_GNT_TIMEOUT_EN
            end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = DROP;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
`endif
            end
         end
         XFER: begin
            // Zero-cycle pass-through: the FIFO head is the cache word.
            cache_wr_valid = !fifo_empty;
            cache_wr_data  = fifo_dout;
            cache_wr_sop   = cache_wr_valid && (cnt_q == '0);
            cache_wr_eop   = cache_wr_valid && (cnt_q == len_m1_c);
            fifo_rd_en     = cache_wr_valid && cache_wr_ready;
            if (fifo_rd_en) begin
               cnt_d = cnt_q + LEN_WIDTH'(1);
               if (cache_wr_eop) state_d = RELEASE;
            end
         end
`ifdef IN_RD_GNT_TIMEOUT_EN
         DROP: begin
            // Drain exactly len words, then flag the discard one cycle later.
            if (cnt_q == len_c) begin
               drop    = 1'b1;
               state_d = RELEASE;
            end else begin
               fifo_rd_en = !fifo_empty;
               if (fifo_rd_en) cnt_d = cnt_q + LEN_WIDTH'(1);
            end
         end
`endif
         RELEASE: begin
            frame_ready = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
